// File: rtl/aes_sbox_sched.sv
// Shared four-lane AES S-box serving round-state SubBytes (4 beats of 32 bits) and
// key-expansion SubWord (1 beat), arbitrated round-robin between the two requesters.
module aes_sbox_sched (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         st_valid_i,
    output logic         st_ready_o,
    input  logic         st_decode_i,
    input  logic [127:0] st_data_i,
    output logic         st_done_o,
    output logic [127:0] st_result_o,
    input  logic         kw_valid_i,
    output logic         kw_ready_o,
    input  logic [31:0]  kw_data_i,
    output logic         kw_done_o,
    output logic [31:0]  kw_result_o,
    output logic         busy_o
);

    typedef enum logic [1:0] {StIdle, StStRun, StKwRun} state_e;

    state_e         state_q, state_d;
    logic [1:0]     beat_q, beat_d;
    logic           ptr_q, ptr_d;
    logic [127:0]   data_q, data_d;
    logic           decode_q, decode_d;
    logic [127:0]   st_result_q, st_result_d;
    logic [31:0]    kw_result_q, kw_result_d;
    logic           st_done_q, st_done_d;
    logic           kw_done_q, kw_done_d;
    logic [31:0]    cur_word, sub_word;
    logic           idle, st_grant, kw_grant;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254; zero maps to zero naturally.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            r    = gf_mul(r, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] aes_forward_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
            ^ 8'h63;
    endfunction

    function automatic logic [7:0] aes_inverse_sbox(input logic [7:0] s);
        logic [7:0] t;
        t = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    assign cur_word = data_q[{beat_q, 5'd0} +: 32];

    for (genvar i = 0; i < 4; i++) begin : g_lane
        logic [7:0] fwd;
        logic [7:0] inv;
        assign fwd = aes_forward_sbox(cur_word[8*i +: 8]);
        assign inv = aes_inverse_sbox(cur_word[8*i +: 8]);
        assign sub_word[8*i +: 8] = decode_q ? inv : fwd;
    end

    // ptr_q = 0 favours the key requester, 1 favours the state requester.
    assign idle       = (state_q == StIdle);
    assign st_ready_o = rst_ni & idle & (~kw_valid_i | ptr_q);
    assign kw_ready_o = rst_ni & idle & (~st_valid_i | ~ptr_q);
    assign st_grant   = st_valid_i & st_ready_o;
    assign kw_grant   = kw_valid_i & kw_ready_o;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        ptr_d       = ptr_q;
        data_d      = data_q;
        decode_d    = decode_q;
        st_result_d = st_result_q;
        kw_result_d = kw_result_q;
        st_done_d   = 1'b0;
        kw_done_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (kw_grant) begin
                    state_d  = StKwRun;
                    data_d   = {96'h0, kw_data_i};
                    decode_d = 1'b0;
                    beat_d   = 2'd0;
                    ptr_d    = 1'b1;
                end else if (st_grant) begin
                    state_d  = StStRun;
                    data_d   = st_data_i;
                    decode_d = st_decode_i;
                    beat_d   = 2'd0;
                    ptr_d    = 1'b0;
                end
            end
            StStRun: begin
                st_result_d[{beat_q, 5'd0} +: 32] = sub_word;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d   = StIdle;
                    st_done_d = 1'b1;
                end
            end
            StKwRun: begin
                kw_result_d = sub_word;
                kw_done_d   = 1'b1;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            beat_q      <= 2'd0;
            ptr_q       <= 1'b0;
            data_q      <= 128'h0;
            decode_q    <= 1'b0;
            st_result_q <= 128'h0;
            kw_result_q <= 32'h0;
            st_done_q   <= 1'b0;
            kw_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            ptr_q       <= ptr_d;
            data_q      <= data_d;
            decode_q    <= decode_d;
            st_result_q <= st_result_d;
            kw_result_q <= kw_result_d;
            st_done_q   <= st_done_d;
            kw_done_q   <= kw_done_d;
        end
    end

    assign st_done_o   = st_done_q;
    assign st_result_o = st_result_q;
    assign kw_done_o   = kw_done_q;
    assign kw_result_o = kw_result_q;
    assign busy_o      = ~idle;

endmodule

// File: doc/aes_sbox_sched.md
AES_SBOX_SCHED -- requirements
Module: aes_sbox_sched

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 rst_n  in  1  reset, synchronous, active-low.
REQ-003 st_valid  in  1  round-state SubBytes request.
REQ-004 st_ready  out  1  state request accepted when st_valid&st_ready at a rising edge.
REQ-005 st_decode  in  1  1 = inverse S-box, 0 = forward; sampled at acceptance.
REQ-006 st_data  in  128  state to substitute; sampled at acceptance.
REQ-007 st_done  out  1  one-cycle pulse marking st_result update.
REQ-008 st_result  out  128  substituted state.
REQ-009 kw_valid  in  1  key-expansion SubWord request, always forward S-box.
REQ-010 kw_ready  out  1  key request accepted when kw_valid&kw_ready at a rising edge.
REQ-011 kw_data  in  32  word to substitute; sampled at acceptance.
REQ-012 kw_done  out  1  one-cycle pulse marking kw_result update.
REQ-013 kw_result  out  32  substituted word.
REQ-014 busy  out  1  high whenever state is not IDLE.

Function
REQ-015 Block SHALL contain exactly four S-box lanes; each lane is an aes_forward_sbox plus an aes_inverse_sbox, output muxed by the latched decode bit; lane i maps byte i (bits 8i+7:8i) of the current 32-bit word.
REQ-016 States SHALL be IDLE, ST_RUN, KW_RUN.
REQ-017 st_ready and kw_ready SHALL be 0 outside IDLE.
REQ-018 In IDLE with only one valid asserted, that requester's ready SHALL be 1.
REQ-019 In IDLE with both valid asserted, only the requester selected by a one-bit round-robin pointer SHALL see ready=1; the other sees 0.
REQ-020 After each grant the pointer SHALL select the other requester; the pointer SHALL be unchanged in cycles without a grant.
REQ-021 State accept: IDLE->ST_RUN; 128-bit input and decode latched; beat counter set to 0.
REQ-022 ST_RUN beat k (k=0..3, one per cycle) SHALL substitute latched bits 32k+31:32k and write them to the same bits of the result register at the cycle-end edge.
REQ-023 After beat 3, the FSM SHALL return to IDLE; st_done SHALL be 1 for exactly the next cycle, with st_result then holding the complete value.
REQ-024 State latency: acceptance in cycle 0, beats in cycles 1-4, st_done in cycle 5.
REQ-025 Key accept: IDLE->KW_RUN; word latched; decode forced to 0.
REQ-026 KW_RUN SHALL last one cycle; the substituted word is written to kw_result; FSM returns to IDLE.
REQ-027 Key latency: acceptance in cycle 0, substitution in cycle 1, kw_done in cycle 2.
REQ-028 A new request SHALL be acceptable in the same cycle that st_done or kw_done is high (back-to-back, no bubble beyond the done cycle).
REQ-029 st_result SHALL change only during an active ST_RUN.
REQ-030 kw_result SHALL change only on KW_RUN completion.
REQ-031 Consumers SHALL read st_result only at st_done; st_result holds its final value until the next state operation begins writing.
REQ-032 Requests arriving while busy SHALL be held by the requester (valid stays high); the block never drops or queues them.
REQ-033 The latched st_decode SHALL be unaffected by input changes after acceptance.

Reset
REQ-034 While rst_n=0 at a rising edge, the block SHALL enter IDLE and clear the beat counter, the pointer (pointer favours key), st_result, kw_result, st_done, kw_done and busy to 0.
REQ-035 Reset asserted mid-operation SHALL abort it with no done pulse; ready is 0 during reset.

Verification
REQ-036 State forward: st_data=128'h0, st_decode=0 -> st_done in cycle 5, st_result=128'h6363...63.
REQ-037 State inverse: st_data=128'h6363...63, st_decode=1 -> st_result=128'h0. Separately, byte 0x7C in every position -> 0x01 in every position.
REQ-038 Key word: kw_data=32'h00010203 -> kw_done in cycle 2, kw_result=32'h637C777B.
REQ-039 Contention: both valid from IDLE after reset -> key granted first, state granted in the key's done cycle. Next contention -> key granted first again, since the pointer favours key after the state grant.
REQ-040 Reset in cycle 3 of a state operation -> no st_done, st_result=0, busy=0, IDLE on the next cycle.
REQ-041 Back-to-back: a second state request held valid through the first's done cycle -> accepted in cycle 5, st_done again in cycle 10. st_decode toggled after acceptance has no effect on the result.
